// File: rtl/ps2_keyboard_rx_if.sv
// Scan-code delivery bus from the PS/2 receiver to the downstream colour/control logic.
interface ps2_keyboard_rx_if;
  logic [7:0] oScanCode;
  logic       oDataValid;
  logic       oBreak;
  logic       oExtended;
  logic       oParityError;
  logic       oFrameError;

  modport master (
    output oScanCode, oDataValid, oBreak, oExtended, oParityError, oFrameError
  );
  modport slave (
    input  oScanCode, oDataValid, oBreak, oExtended, oParityError, oFrameError
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit deframing,
// break/extended prefix folding and one registered strobe per key event.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPS2Clk,
  input  logic              iPS2Data,
  ps2_keyboard_rx_if.master kbd
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          brk_pend, ext_pend;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= iPS2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= iPS2Data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples at the new level.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      to_cnt           <= '0;
      shreg            <= '0;
      par_bit          <= 1'b0;
      brk_pend         <= 1'b0;
      ext_pend         <= 1'b0;
      kbd.oScanCode    <= '0;
      kbd.oDataValid   <= 1'b0;
      kbd.oBreak       <= 1'b0;
      kbd.oExtended    <= 1'b0;
      kbd.oParityError <= 1'b0;
      kbd.oFrameError  <= 1'b0;
    end else begin
      kbd.oDataValid   <= 1'b0;
      kbd.oParityError <= 1'b0;
      kbd.oFrameError  <= 1'b0;
      // An edge pulse wins over a coincident timeout terminal count.
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_s2) begin
              kbd.oFrameError <= 1'b1;
            end else if (!(^{shreg, par_bit})) begin
              kbd.oParityError <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext_pend <= 1'b1;
            end else begin
              kbd.oScanCode  <= shreg;
              kbd.oBreak     <= brk_pend;
              kbd.oExtended  <= ext_pend;
              kbd.oDataValid <= 1'b1;
              brk_pend       <= 1'b0;
              ext_pend       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        kbd.oFrameError <= 1'b1;
        state           <= IDLE;
        brk_pend        <= 1'b0;
        ext_pend        <= 1'b0;
        to_cnt          <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: PS/2 frames driven on the raw lines,
// strobes and payload checked against hand-computed values.
module tb_ps2_keyboard_rx;
  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT    = 200;
  localparam int unsigned HALF       = 20;
  localparam int unsigned LAT        = 2 + FILTER_LEN + 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iPS2Clk  (ps2_clk),
    .iPS2Data (ps2_data),
    .kbd      (bus)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int unsigned tests = 0, fails = 0;
  int unsigned dv_n = 0, pe_n = 0, fe_n = 0;
  int unsigned dv_cyc = 0, fe_cyc = 0, last_fall = 0;
  logic [7:0] cap_code = '0;
  logic cap_brk = 1'b0, cap_ext = 1'b0;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.oDataValid) begin
        dv_n++;
        dv_cyc   = cyc;
        cap_code = bus.oScanCode;
        cap_brk  = bus.oBreak;
        cap_ext  = bus.oExtended;
      end
      if (bus.oParityError) pe_n++;
      if (bus.oFrameError) begin
        fe_n++;
        fe_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par_flip, input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  task automatic ps2_send(input logic [10:0] bits, input int unsigned n, input bit glitch);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge Clock);
      ps2_data = bits[i];
      repeat (HALF) @(negedge Clock);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge Clock);
      ps2_clk = 1'b1;
      if (glitch) begin
        repeat (8) @(negedge Clock);
        ps2_clk = 1'b0;
        repeat (2) @(negedge Clock);
        ps2_clk = 1'b1;
        repeat (HALF - 10) @(negedge Clock);
      end else begin
        repeat (HALF) @(negedge Clock);
      end
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge Clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_send(frame(b, 1'b0, 1'b1), 11, 1'b0);
  endtask

  int unsigned dv0, pe0, fe0;

  task automatic snap();
    dv0 = dv_n; pe0 = pe_n; fe0 = fe_n;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("reset_scancode", {24'd0, bus.oScanCode}, 32'h0);
    check("reset_strobes", {26'd0, bus.oDataValid, bus.oBreak, bus.oExtended,
                            bus.oParityError, bus.oFrameError, 1'b0}, 32'h0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    snap();
    send_byte(8'h1C);
    check("1c_dv_count", dv_n - dv0, 1);
    check("1c_code", {24'd0, cap_code}, 32'h1C);
    check("1c_flags", {30'd0, cap_brk, cap_ext}, 0);
    check("1c_latency", dv_cyc - last_fall, LAT);
    check("1c_errors", pe_n - pe0 + fe_n - fe0, 0);

    snap();
    send_byte(8'hF0);
    check("f0_no_dv", dv_n - dv0, 0);
    send_byte(8'h1C);
    check("brk_dv_count", dv_n - dv0, 1);
    check("brk_code", {24'd0, cap_code}, 32'h1C);
    check("brk_flag", {31'd0, cap_brk}, 1);
    send_byte(8'h1C);
    check("brk_cleared", {31'd0, cap_brk}, 0);

    snap();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext_dv_count", dv_n - dv0, 1);
    check("ext_code", {24'd0, cap_code}, 32'h75);
    check("ext_flags", {30'd0, cap_ext, cap_brk}, 32'h3);
    send_byte(8'h29);
    check("ext_after_code", {24'd0, cap_code}, 32'h29);
    check("ext_after_flags", {30'd0, cap_ext, cap_brk}, 0);

    snap();
    ps2_send(frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
    check("par_pe_count", pe_n - pe0, 1);
    check("par_no_dv", dv_n - dv0, 0);
    check("par_code_held", {24'd0, bus.oScanCode}, 32'h29);
    snap();
    ps2_send(frame(8'h29, 1'b0, 1'b0), 11, 1'b0);
    check("stop_fe_count", fe_n - fe0, 1);
    check("stop_other", dv_n - dv0 + pe_n - pe0, 0);

    snap();
    ps2_send(frame(8'h1C, 1'b0, 1'b1), 4, 1'b0);
    repeat (TIMEOUT + 100) @(negedge Clock);
    check("to_fe_count", fe_n - fe0, 1);
    check("to_latency", fe_cyc - last_fall, LAT + TIMEOUT);
    check("to_no_dv", dv_n - dv0, 0);
    snap();
    send_byte(8'h29);
    check("to_next_dv", dv_n - dv0, 1);
    check("to_next_code", {24'd0, cap_code}, 32'h29);

    snap();
    ps2_send(frame(8'h1C, 1'b0, 1'b1), 11, 1'b1);
    check("glitch_dv_count", dv_n - dv0, 1);
    check("glitch_code", {24'd0, cap_code}, 32'h1C);
    check("glitch_errors", pe_n - pe0 + fe_n - fe0, 0);

    snap();
    ps2_send(frame(8'hE0, 1'b0, 1'b1), 5, 1'b0);
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    check("rst_mid_code", {24'd0, bus.oScanCode}, 32'h0);
    Reset = 1'b0;
    repeat (TIMEOUT + 20) @(negedge Clock);
    check("rst_mid_no_strobe", dv_n - dv0 + pe_n - pe0 + fe_n - fe0, 0);
    send_byte(8'h1C);
    check("rst_next_dv", dv_n - dv0, 1);
    check("rst_next_code", {24'd0, cap_code}, 32'h1C);
    check("rst_next_flags", {30'd0, cap_brk, cap_ext}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver, the front end of the keyboard path (SP2 stage).
- Synchronises and filters the raw PS/2 clock and data lines, then deframes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Folds the 0xF0 (break) and 0xE0 (extended) prefixes into flags.
- Delivers one scan-code strobe per key event to the downstream colour/control logic that drives VGA_SYNC iRed/iGreen/iBlue.

Parameters:
- FILTER_LEN, 4: number of consecutive identical synchronised PS/2 clock samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 5000: Clock cycles allowed between PS/2 clock falling edges mid-frame before the frame is aborted (100 us at 50 MHz).

Ports:
- Clock  input  1  system clock, all logic on posedge.
- Reset  input  1  asynchronous active-high reset.
- iPS2Clk  input  1  raw PS/2 clock line, asynchronous.
- iPS2Data  input  1  raw PS/2 data line, asynchronous.
- oScanCode  output  8  last delivered scan code; holds until the next delivery.
- oDataValid  output  1  one-cycle strobe; oScanCode, oBreak and oExtended are valid in this cycle.
- oBreak  output  1  delivered code was preceded by 0xF0.
- oExtended  output  1  delivered code was preceded by 0xE0.
- oParityError  output  1  one-cycle strobe on a parity failure.
- oFrameError  output  1  one-cycle strobe on a bad stop bit or a timeout.

Behaviour:
- Reset: Clock and Reset follow the codebase naming; reset is asynchronous active-high.
  - All outputs go to 0, state goes to IDLE, and the bit counter, timeout counter, shift register and pending flags clear.
  - The synchroniser stages and the filtered clock reset to 1 (bus idle high).
- Synchronisation: both lines pass through 2-FF synchronisers.
- Filter: a filter counter tracks the synchronised clock. The filtered clock takes the new level only after FILTER_LEN consecutive samples at that level. Shorter glitches are ignored.
- Edge detect: a falling edge is a filtered-clock 1->0 transition, and produces a single-cycle internal pulse. Synchronised data is sampled in that same cycle.
- States and transitions, all advancing only on an edge pulse except the timeout:
  - IDLE: data=0 goes to DATA with bit count 0. data=1 is a spurious edge; stay in IDLE with no error.
  - DATA: shift right, the new bit entering bit 7; count increments. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: evaluate the frame, then return to IDLE.
- Frame evaluation at the STOP edge, priority high to low:
  - Stop bit = 0: oFrameError pulses.
  - XOR of 8 data bits and parity = 0 (even count): oParityError pulses.
  - Byte = 0xF0: set break_pending; no strobe.
  - Byte = 0xE0: set ext_pending; no strobe.
  - Any other byte: load oScanCode, copy the pending flags to oBreak/oExtended, pulse oDataValid, then clear both pending flags.
- Strobes: every strobe (oDataValid, oParityError, oFrameError) is registered and high for exactly 1 cycle. It is asserted the cycle after the stop-bit edge pulse.
- Error frames: leave oScanCode, oBreak, oExtended and the pending flags unchanged.
- Latency: raw stop-bit falling edge to strobe = 2 (sync) + FILTER_LEN + 1 cycles.
- Timeout:
  - The counter clears on every edge pulse and in IDLE, and increments otherwise.
  - If it reaches TIMEOUT_CYCLES-1 in a non-IDLE state: oFrameError pulses, state goes to IDLE, and both pending flags clear.
- Simultaneous events: an edge pulse in the same cycle as the timeout terminal count takes precedence, so there is no timeout.
- Reset mid-frame: the partial frame is discarded with no strobe. The next frame decodes normally once the filtered clock is high.
- Host-to-device transmission is not supported; both PS/2 lines are input-only.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 12.5 kHz PS/2 clock -> single oDataValid, oScanCode=0x1C, oBreak=0, oExtended=0.
- Frames 0xF0 then 0x1C -> exactly one oDataValid, oScanCode=0x1C, oBreak=1. A following 0x1C -> oBreak=0.
- Frames 0xE0, 0xF0, 0x75 -> one oDataValid, oScanCode=0x75, oExtended=1, oBreak=1. Frame 0x29 afterwards -> both flags 0.
- Frame 0x1C with parity=1 -> oParityError 1 cycle, no oDataValid, oScanCode keeps its prior value. A stop bit of 0 on a valid 0x29 -> oFrameError only.
- Start bit + 3 data bits, then clock held high -> oFrameError exactly TIMEOUT_CYCLES cycles after the last edge, state IDLE. A following 0x29 frame decodes correctly.
- Glitch: 2-cycle low pulses on iPS2Clk in the middle of the 0x1C bit period -> no extra bit shifted, 0x1C still decoded.
- Reset asserted after bit 4 -> no strobe. The subsequent full 0x1C frame decodes correctly.
